// File: rtl/ws2812_frame_sequencer.sv
// ----------------------------------------------------------------------------
// ws2812_frame_sequencer
//
// Frame-level controller for the WS2812 strip datapath. For every frame it
// walks pixel indices 0..NUM_PIXELS-1. For each index it issues a one-cycle
// read strobe to the color generator and captures the GRB color one cycle
// later. It then offers that word to the bit serializer over valid/ready.
// After the last pixel it waits for the serializer to go idle and holds the
// line low for LATCH_CYCLES clocks. It then steps the animation phase and
// pulses o_frame_done.
//
// Optional feature macro: WS2812_FRAME_SYNC_EN
//   defined   : adds i_frame_sync; a frame starts only when i_enable and
//               i_frame_sync are high in the same IDLE cycle. Sync pulses
//               seen outside IDLE are dropped.
//   undefined : frames free-run whenever i_enable is high.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        asynchronous active-high reset, clears all state
//   i_enable       start frames while high
//   o_px_idx       pixel index presented to the color generator
//   o_px_rd        one-cycle read strobe qualifying o_px_idx
//   i_px_color     GRB color, valid exactly one cycle after o_px_rd
//   o_tx_data      GRB word to the serializer
//   o_tx_valid     o_tx_data valid
//   i_tx_ready     serializer accepts the word when o_tx_valid & i_tx_ready
//   i_tx_busy      serializer still shifting bits (only looked at in DRAIN)
//   o_phase        animation phase, advanced once per frame
//   o_frame_done   one-cycle pulse at the end of each latch gap
//   o_busy         high in every state except IDLE
//   i_frame_sync   frame start qualifier (WS2812_FRAME_SYNC_EN only)
// ----------------------------------------------------------------------------
module ws2812_frame_sequencer #(
  parameter int NUM_PIXELS   = 48,
  parameter int IDX_W        = 6,
  parameter int LATCH_CYCLES = 5000,
  parameter int PHASE_W      = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  output logic [IDX_W-1:0]   o_px_idx,
  output logic               o_px_rd,
  input  logic [23:0]        i_px_color,
  output logic [23:0]        o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  input  logic               i_tx_busy,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_frame_done,
  output logic               o_busy
`ifdef WS2812_FRAME_SYNC_EN
  ,
  input  logic               i_frame_sync
`endif
);

  // Counter must be at least one bit wide even for LATCH_CYCLES == 1.
  localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_DRAIN,
    S_LATCH
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_px_idx;
  logic [IDX_W-1:0]   w_px_idx_next;
  logic               r_px_rd;
  logic               w_px_rd_next;
  logic [23:0]        r_tx_data;
  logic [23:0]        w_tx_data_next;
  logic               r_tx_valid;
  logic               w_tx_valid_next;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_phase_next;
  logic               r_frame_done;
  logic               w_frame_done_next;
  logic               r_busy;
  logic               w_busy_next;
  logic [CNT_W-1:0]   r_latch_cnt;
  logic [CNT_W-1:0]   w_latch_cnt_next;
  logic               w_start;

`ifdef WS2812_FRAME_SYNC_EN
  // Sync is only sampled in IDLE, so pulses elsewhere are simply lost.
  assign w_start = i_enable & i_frame_sync;
`else
  assign w_start = i_enable;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_px_idx     <= '0;
      r_px_rd      <= 1'b0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_phase      <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_latch_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_px_idx     <= w_px_idx_next;
      r_px_rd      <= w_px_rd_next;
      r_tx_data    <= w_tx_data_next;
      r_tx_valid   <= w_tx_valid_next;
      r_phase      <= w_phase_next;
      r_frame_done <= w_frame_done_next;
      r_busy       <= w_busy_next;
      r_latch_cnt  <= w_latch_cnt_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_px_idx_next     = r_px_idx;
    w_tx_data_next    = r_tx_data;
    w_tx_valid_next   = r_tx_valid;
    w_phase_next      = r_phase;
    w_frame_done_next = 1'b0;
    w_latch_cnt_next  = r_latch_cnt;

    case (r_state)
      S_IDLE: begin
        w_px_idx_next = '0;
        if (w_start) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // Generator output is valid in this cycle, one after the strobe.
        w_tx_data_next  = i_px_color;
        w_tx_valid_next = 1'b1;
        w_state_next    = S_SEND;
      end
      S_SEND: begin
        if (r_tx_valid && i_tx_ready) begin
          w_tx_valid_next = 1'b0;
          if (r_px_idx == LAST_IDX) begin
            w_state_next = S_DRAIN;
          end else begin
            w_px_idx_next = r_px_idx + IDX_W'(1);
            w_state_next  = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (!i_tx_busy) begin
          w_latch_cnt_next = LATCH_LOAD;
          w_state_next     = S_LATCH;
        end
      end
      S_LATCH: begin
        if (r_latch_cnt == '0) begin
          w_frame_done_next = 1'b1;
          w_phase_next      = r_phase + PHASE_W'(1);
          w_px_idx_next     = '0;
          w_state_next      = S_IDLE;
        end else begin
          w_latch_cnt_next = r_latch_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Strobe and busy are derived from the next state so that, once
    // registered, they line up with the state they describe.
    w_px_rd_next = (w_state_next == S_FETCH);
    w_busy_next  = (w_state_next != S_IDLE);
  end

  assign o_px_idx     = r_px_idx;
  assign o_px_rd      = r_px_rd;
  assign o_tx_data    = r_tx_data;
  assign o_tx_valid   = r_tx_valid;
  assign o_phase      = r_phase;
  assign o_frame_done = r_frame_done;
  assign o_busy       = r_busy;

endmodule
